simt_divergence_ctrl: RTL and testbench

SIMT_DIVERGENCE_CTRL -- requirements
Module: simt_divergence_ctrl

---
 rtl/simt_divergence_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_simt_divergence_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simt_divergence_ctrl.sv
// simt_divergence_ctrl
// SIMT branch divergence / reconvergence controller for one warp. Drives an
// external SIMT stack through push/pop strobes and reads its top entry
// combinationally. Divergent branches push a reconvergence entry and a
// not-taken entry, then run the taken lanes; reaching the current sync PC
// pops the stack and redirects fetch.
// Optional feature macro: SIMT_DIV_STATS_EN enables div_count / max_depth.
//
// Handshake: a branch transfers on a cycle where br_valid and br_ready are
// both 1. The front end holds br_* stable while br_valid=1 and br_ready=0,
// and holds fetch_pc / br_* whenever stall=1. br_ready never depends on
// br_valid.
module simt_divergence_ctrl #(
  parameter  int THREADS = 4,
  parameter  int DEPTH   = 16,
  localparam int DW      = $clog2(DEPTH) + 1
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               br_valid,
  output logic               br_ready,
  input  logic [THREADS-1:0] br_taken,
  input  logic [31:0]        br_target,
  input  logic [31:0]        br_fallthru,
  input  logic [31:0]        br_reconv,
  input  logic               fetch_valid,
  input  logic [31:0]        fetch_pc,
  output logic               stk_push,
  output logic               stk_pop,
  output logic [THREADS-1:0] stk_new_mask,
  output logic [31:0]        stk_new_sync,
  output logic [31:0]        stk_new_addr,
  input  logic [THREADS-1:0] stk_top_mask,
  input  logic [31:0]        stk_top_sync,
  input  logic [31:0]        stk_top_addr,
  output logic [THREADS-1:0] active_mask,
  output logic               redirect_en,
  output logic [31:0]        redirect_pc,
  output logic               stall,
  output logic [DW-1:0]      depth,
  output logic               err_ovf,
  output logic [15:0]        div_count,
  output logic [DW-1:0]      max_depth,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUSH_RC = 2'd1,
    PUSH_NT = 2'd2,
    POP     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [THREADS-1:0] active_mask_q, active_mask_d;
  logic [31:0]        cur_sync_q, cur_sync_d;
  logic [DW-1:0]      depth_q, depth_d;
  logic               err_ovf_q, err_ovf_d;
  // Branch payload captured at accept so br_* may change during the pushes.
  logic [THREADS-1:0] t_q, t_d;
  logic [31:0]        tgt_q, tgt_d;
  logic [31:0]        ft_q, ft_d;
  logic [31:0]        rc_q, rc_d;

  logic               hit;
  logic [THREADS-1:0] t_now;

  assign hit   = (state_q == IDLE) & fetch_valid & (depth_q != '0) & (fetch_pc == cur_sync_q);
  assign t_now = br_taken & active_mask_q;

  // Next-state, stack payload and fetch redirect decode.
  always_comb begin
    state_d       = state_q;
    active_mask_d = active_mask_q;
    cur_sync_d    = cur_sync_q;
    depth_d       = depth_q;
    err_ovf_d     = err_ovf_q;
    t_d           = t_q;
    tgt_d         = tgt_q;
    ft_d          = ft_q;
    rc_d          = rc_q;
    br_ready      = 1'b0;
    stk_push      = 1'b0;
    stk_pop       = 1'b0;
    stk_new_mask  = '0;
    stk_new_sync  = '0;
    stk_new_addr  = '0;
    redirect_en   = 1'b0;
    redirect_pc   = '0;
    stall         = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Reconvergence takes priority over a waiting branch; nothing is
        // accepted while reset is asserted.
        br_ready = nRST & ~hit;
        if (hit) begin
          stall   = 1'b1;
          state_d = POP;
        end else if (br_valid && br_ready) begin
          if (t_now == active_mask_q) begin
            redirect_en = 1'b1;
            redirect_pc = br_target;
          end else if (t_now != '0) begin
            // Two entries are needed; refuse the split if they do not fit.
            if (depth_q > DW'(DEPTH - 2)) begin
              err_ovf_d = 1'b1;
            end else begin
              t_d     = t_now;
              tgt_d   = br_target;
              ft_d    = br_fallthru;
              rc_d    = br_reconv;
              state_d = PUSH_RC;
            end
          end
        end
      end
      PUSH_RC: begin
        stall        = 1'b1;
        stk_push     = 1'b1;
        stk_new_mask = active_mask_q;
        stk_new_sync = cur_sync_q;
        stk_new_addr = rc_q;
        depth_d      = depth_q + DW'(1);
        state_d      = PUSH_NT;
      end
      PUSH_NT: begin
        stall         = 1'b1;
        stk_push      = 1'b1;
        stk_new_mask  = active_mask_q & ~t_q;
        stk_new_sync  = rc_q;
        stk_new_addr  = ft_q;
        depth_d       = depth_q + DW'(1);
        active_mask_d = t_q;
        cur_sync_d    = rc_q;
        redirect_en   = 1'b1;
        redirect_pc   = tgt_q;
        state_d       = IDLE;
      end
      POP: begin
        stall         = 1'b1;
        stk_pop       = 1'b1;
        redirect_en   = 1'b1;
        redirect_pc   = stk_top_addr;
        active_mask_d = stk_top_mask;
        cur_sync_d    = stk_top_sync;
        depth_d       = depth_q - DW'(1);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= IDLE;
      active_mask_q <= '1;
      cur_sync_q    <= '0;
      depth_q       <= '0;
      err_ovf_q     <= 1'b0;
      t_q           <= '0;
      tgt_q         <= '0;
      ft_q          <= '0;
      rc_q          <= '0;
    end else begin
      state_q       <= state_d;
      active_mask_q <= active_mask_d;
      cur_sync_q    <= cur_sync_d;
      depth_q       <= depth_d;
      err_ovf_q     <= err_ovf_d;
      t_q           <= t_d;
      tgt_q         <= tgt_d;
      ft_q          <= ft_d;
      rc_q          <= rc_d;
    end
  end

  assign active_mask = active_mask_q;
  assign depth       = depth_q;
  assign err_ovf     = err_ovf_q;
  assign dbg_state   = state_q;

`ifdef SIMT_DIV_STATS_EN
  logic [15:0]   div_count_q, div_count_d;
  logic [DW-1:0] max_depth_q, max_depth_d;

  // One divergent branch is counted when its second entry is pushed.
  always_comb begin
    div_count_d = div_count_q;
    if (state_q == PUSH_NT && div_count_q != 16'hFFFF) begin
      div_count_d = div_count_q + 16'd1;
    end
    max_depth_d = (depth_d > max_depth_q) ? depth_d : max_depth_q;
  end

  // Statistics registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      div_count_q <= '0;
      max_depth_q <= '0;
    end else begin
      div_count_q <= div_count_d;
      max_depth_q <= max_depth_d;
    end
  end

  assign div_count = div_count_q;
  assign max_depth = max_depth_q;
`else
  assign div_count = '0;
  assign max_depth = '0;
`endif

endmodule

// File: tb/tb_simt_divergence_ctrl.sv
// Bench for simt_divergence_ctrl: directed sequence plus randomized
// branch/reconvergence traffic against a warp-level stack model. A second
// wide instance (16 lanes) is used to nest deep enough to hit overflow.
module tb_simt_divergence_ctrl;
  localparam int TH = 4;
  localparam int DP = 16;
  localparam int DW = 5;

  typedef struct packed {
    logic [TH-1:0] m;
    logic [31:0]   s;
    logic [31:0]   a;
  } ent_t;

  // ---------------- clock / reset ----------------
  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- main instance signals ----------------
  logic          br_valid, br_ready;
  logic [TH-1:0] br_taken;
  logic [31:0]   br_target, br_fallthru, br_reconv;
  logic          fetch_valid;
  logic [31:0]   fetch_pc;
  logic          stk_push, stk_pop;
  logic [TH-1:0] stk_new_mask;
  logic [31:0]   stk_new_sync, stk_new_addr;
  logic [TH-1:0] stk_top_mask = '0;
  logic [31:0]   stk_top_sync = '0;
  logic [31:0]   stk_top_addr = '0;
  logic [TH-1:0] active_mask;
  logic          redirect_en;
  logic [31:0]   redirect_pc;
  logic          stall;
  logic [DW-1:0] depth, max_depth;
  logic          err_ovf;
  logic [15:0]   div_count;
  logic [1:0]    dbg_state;

  simt_divergence_ctrl #(.THREADS(TH), .DEPTH(DP)) dut (
    .CLK(CLK), .nRST(nRST),
    .br_valid(br_valid), .br_ready(br_ready), .br_taken(br_taken),
    .br_target(br_target), .br_fallthru(br_fallthru), .br_reconv(br_reconv),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_new_mask(stk_new_mask), .stk_new_sync(stk_new_sync), .stk_new_addr(stk_new_addr),
    .stk_top_mask(stk_top_mask), .stk_top_sync(stk_top_sync), .stk_top_addr(stk_top_addr),
    .active_mask(active_mask), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .stall(stall), .depth(depth), .err_ovf(err_ovf),
    .div_count(div_count), .max_depth(max_depth), .dbg_state(dbg_state)
  );

  // ---------------- wide instance for overflow ----------------
  logic        w_br_valid, w_br_ready;
  logic [15:0] w_br_taken, w_new_mask, w_active, w_div;
  logic        w_stk_push, w_stk_pop, w_redirect_en, w_stall, w_err;
  logic [31:0] w_new_sync, w_new_addr, w_redirect_pc;
  logic [4:0]  w_depth, w_max_depth;
  logic [1:0]  w_dbg;
  int          w_push_cnt;

  simt_divergence_ctrl #(.THREADS(16), .DEPTH(16)) dut_w (
    .CLK(CLK), .nRST(nRST),
    .br_valid(w_br_valid), .br_ready(w_br_ready), .br_taken(w_br_taken),
    .br_target(32'h0000_1000), .br_fallthru(32'h0000_1004), .br_reconv(32'h0000_2000),
    .fetch_valid(1'b0), .fetch_pc(32'h0),
    .stk_push(w_stk_push), .stk_pop(w_stk_pop),
    .stk_new_mask(w_new_mask), .stk_new_sync(w_new_sync), .stk_new_addr(w_new_addr),
    .stk_top_mask(16'h0), .stk_top_sync(32'h0), .stk_top_addr(32'h0),
    .active_mask(w_active), .redirect_en(w_redirect_en), .redirect_pc(w_redirect_pc),
    .stall(w_stall), .depth(w_depth), .err_ovf(w_err),
    .div_count(w_div), .max_depth(w_max_depth), .dbg_state(w_dbg)
  );

  always @(posedge CLK) begin
    if (!nRST) w_push_cnt <= 0;
    else if (w_stk_push) w_push_cnt <= w_push_cnt + 1;
  end

  // ---------------- external SIMT stack memory ----------------
  ent_t mem_q[$];
  ent_t mem_e;
  always @(posedge CLK) begin
    if (!nRST) begin
      mem_q.delete();
    end else if (stk_push) begin
      mem_e.m = stk_new_mask;
      mem_e.s = stk_new_sync;
      mem_e.a = stk_new_addr;
      mem_q.push_back(mem_e);
    end else if (stk_pop && mem_q.size() > 0) begin
      mem_q.delete(mem_q.size() - 1);
    end
    if (mem_q.size() > 0) begin
      stk_top_mask <= mem_q[mem_q.size()-1].m;
      stk_top_sync <= mem_q[mem_q.size()-1].s;
      stk_top_addr <= mem_q[mem_q.size()-1].a;
    end else begin
      stk_top_mask <= '0;
      stk_top_sync <= '0;
      stk_top_addr <= '0;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  int            n_cmp = 0;
  int            n_bad = 0;
  ent_t          m_stk[$];
  logic [TH-1:0] m_active;
  logic [31:0]   m_sync;
  logic          m_err;
  int            m_div, m_max;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_active = '1;
    m_sync   = '0;
    m_err    = 1'b0;
    m_div    = 0;
    m_max    = 0;
  endtask

  task automatic idle_inputs();
    br_valid = 1'b0; br_taken = '0;
    br_target = '0; br_fallthru = '0; br_reconv = '0;
    fetch_valid = 1'b0; fetch_pc = '0;
    w_br_valid = 1'b0; w_br_taken = '0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "/depth"}, depth, m_stk.size());
    check({tag, "/active"}, active_mask, m_active);
    check({tag, "/err"}, err_ovf, m_err);
    check({tag, "/memsize"}, mem_q.size(), m_stk.size());
    if (m_stk.size() > 0 && mem_q.size() == m_stk.size()) begin
      check({tag, "/top_mask"}, mem_q[mem_q.size()-1].m, m_stk[m_stk.size()-1].m);
      check({tag, "/top_sync"}, mem_q[mem_q.size()-1].s, m_stk[m_stk.size()-1].s);
      check({tag, "/top_addr"}, mem_q[mem_q.size()-1].a, m_stk[m_stk.size()-1].a);
    end
`ifdef SIMT_DIV_STATS_EN
    check({tag, "/div_count"}, div_count, m_div);
    check({tag, "/max_depth"}, max_depth, m_max);
`else
    check({tag, "/div_count"}, div_count, 0);
    check({tag, "/max_depth"}, max_depth, 0);
`endif
  endtask

  // Present one branch; follow it through any pushes; compare with model.
  task automatic do_branch(input logic [TH-1:0] taken, input logic [31:0] tgt,
                           input logic [31:0] ft, input logic [31:0] rc);
    logic [TH-1:0] t;
    ent_t e;
    @(negedge CLK);
    br_valid = 1'b1; br_taken = taken; br_target = tgt;
    br_fallthru = ft; br_reconv = rc; fetch_valid = 1'b0;
    #1;
    t = taken & m_active;
    check("acc/br_ready", br_ready, 1);
    check("acc/stall", stall, 0);
    check("acc/push", stk_push, 0);
    if (t == m_active) begin
      check("uni/redirect_en", redirect_en, 1);
      check("uni/redirect_pc", redirect_pc, tgt);
    end else begin
      check("acc/redirect_en", redirect_en, 0);
    end
    @(negedge CLK);
    br_valid = 1'b0;
    if (t != m_active && t != '0) begin
      if (m_stk.size() > DP - 2) begin
        m_err = 1'b1;
        #1 check("ovf/push", stk_push, 0);
      end else begin
        // Payload was captured at accept; disturb the inputs.
        br_taken = TH'($urandom); br_target = $urandom;
        br_fallthru = $urandom; br_reconv = $urandom;
        #1;
        check("rc/push", stk_push, 1);
        check("rc/pop", stk_pop, 0);
        check("rc/stall", stall, 1);
        check("rc/br_ready", br_ready, 0);
        check("rc/redirect_en", redirect_en, 0);
        check("rc/mask", stk_new_mask, m_active);
        check("rc/sync", stk_new_sync, m_sync);
        check("rc/addr", stk_new_addr, rc);
        @(negedge CLK); #1;
        check("nt/push", stk_push, 1);
        check("nt/pop", stk_pop, 0);
        check("nt/stall", stall, 1);
        check("nt/mask", stk_new_mask, m_active & ~t);
        check("nt/sync", stk_new_sync, rc);
        check("nt/addr", stk_new_addr, ft);
        check("nt/redirect_en", redirect_en, 1);
        check("nt/redirect_pc", redirect_pc, tgt);
        e.m = m_active; e.s = m_sync; e.a = rc;
        m_stk.push_back(e);
        e.m = m_active & ~t; e.s = rc; e.a = ft;
        m_stk.push_back(e);
        m_active = t;
        m_sync   = rc;
        m_div++;
        if (m_stk.size() > m_max) m_max = m_stk.size();
        @(negedge CLK);
      end
    end
    #1 check_state("br");
  endtask

  // Fetch reaches the sync PC; optionally a uniform branch waits meanwhile.
  task automatic do_reconv(input bit hold_br);
    ent_t e;
    @(negedge CLK);
    fetch_valid = 1'b1; fetch_pc = m_sync;
    if (hold_br) begin
      br_valid = 1'b1; br_taken = '1; br_target = 32'h0000_4000;
      br_fallthru = 32'h0000_4004; br_reconv = 32'h0000_4800;
    end
    #1;
    check("hit/stall", stall, 1);
    check("hit/br_ready", br_ready, 0);
    check("hit/redirect_en", redirect_en, 0);
    check("hit/push", stk_push, 0);
    check("hit/pop", stk_pop, 0);
    @(negedge CLK);
    fetch_valid = 1'b0;
    #1;
    e = m_stk[m_stk.size()-1];
    check("pop/pop", stk_pop, 1);
    check("pop/push", stk_push, 0);
    check("pop/stall", stall, 1);
    check("pop/redirect_en", redirect_en, 1);
    check("pop/redirect_pc", redirect_pc, e.a);
    if (hold_br) check("pop/br_ready", br_ready, 0);
    m_stk.delete(m_stk.size() - 1);
    m_active = e.m;
    m_sync   = e.s;
    @(negedge CLK); #1;
    check_state("pop");
    if (hold_br) begin
      check("late/br_ready", br_ready, 1);
      check("late/redirect_en", redirect_en, 1);
      check("late/redirect_pc", redirect_pc, 32'h0000_4000);
      @(negedge CLK);
      br_valid = 1'b0;
      #1 check_state("late");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] w_mask;
    logic [15:0] w_t;
    idle_inputs();
    model_reset();

    // Reset values, with a uniform branch offered during reset.
    repeat (3) @(negedge CLK);
    br_valid = 1'b1; br_taken = '1; br_target = 32'h0000_0100;
    #1;
    check("rst/push", stk_push, 0);
    check("rst/pop", stk_pop, 0);
    check("rst/redirect_en", redirect_en, 0);
    check("rst/redirect_pc", redirect_pc, 0);
    check("rst/stall", stall, 0);
    check("rst/br_ready", br_ready, 0);
    check("rst/depth", depth, 0);
    check("rst/active", active_mask, 4'b1111);
    check("rst/err", err_ovf, 0);
    br_valid = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check("idle/br_ready", br_ready, 1);
    check("idle/active", active_mask, 4'b1111);
    check_state("idle");

    // Uniform taken, uniform not-taken, then a 2-way split.
    do_branch(4'b1111, 32'h0000_0100, 32'h0000_0004, 32'h0000_0008);
    do_branch(4'b0000, 32'h0000_0180, 32'h0000_0104, 32'h0000_0200);
    do_branch(4'b0011, 32'h0000_0200, 32'h0000_0104, 32'h0000_0300);
    check("split/active", active_mask, 4'b0011);
    check("split/depth", depth, 2);
`ifdef SIMT_DIV_STATS_EN
    check("split/div_count", div_count, 1);
    check("split/max_depth", max_depth, 2);
`endif
    do_reconv(1'b0);
    check("rc1/active", active_mask, 4'b1100);
    check("rc1/depth", depth, 1);
    do_reconv(1'b0);
    check("rc2/active", active_mask, 4'b1111);
    check("rc2/depth", depth, 0);

    // Reconvergence hit while a branch waits: pop first, branch after.
    do_branch(4'b0101, 32'h0000_0500, 32'h0000_0504, 32'h0000_0600);
    do_reconv(1'b1);
    do_reconv(1'b0);

    // Overflow on the 16-lane instance: 8 nested splits fill 16 entries.
    w_mask = 16'hFFFF;
    for (int k = 0; k < 9; k++) begin
      w_t = w_mask >> 1;
      @(negedge CLK);
      w_br_valid = 1'b1; w_br_taken = w_t;
      #1;
      check("w/br_ready", w_br_ready, 1);
      check("w/redirect_en", w_redirect_en, 0);
      check("w/depth_before", w_depth, 2 * k);
      @(negedge CLK);
      w_br_valid = 1'b0;
      #1;
      check("w/push", w_stk_push, (k < 8) ? 1 : 0);
      check("w/err", w_err, (k < 8) ? 0 : 1);
      repeat (2) @(negedge CLK);
      if (k < 8) w_mask = w_t;
    end
    #1;
    check("w/depth_final", w_depth, 16);
    check("w/push_cnt", w_push_cnt, 16);
    check("w/err_sticky", w_err, 1);
    check("w/active", w_active, w_mask);

    // Randomized branch / reconvergence traffic.
    repeat (250) begin
      if (m_stk.size() > 0 && $urandom_range(0, 2) == 0) begin
        do_reconv(1'b0);
      end else begin
        do_branch(TH'($urandom_range(0, 15)), {$urandom} & ~32'h3,
                  {$urandom} & ~32'h3, {$urandom} & ~32'h3);
      end
    end

    // Reset while the second push is in flight.
    @(negedge CLK); nRST = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    model_reset();
    @(negedge CLK);
    br_valid = 1'b1; br_taken = 4'b0011; br_target = 32'h0000_0700;
    br_fallthru = 32'h0000_0704; br_reconv = 32'h0000_0800;
    @(negedge CLK);
    br_valid = 1'b0;
    @(negedge CLK);
    #1 check("prerst/push", stk_push, 1);
    nRST = 1'b0;
    #1;
    check("midrst/push", stk_push, 0);
    check("midrst/stall", stall, 0);
    check("midrst/redirect_en", redirect_en, 0);
    check("midrst/redirect_pc", redirect_pc, 0);
    check("midrst/depth", depth, 0);
    check("midrst/active", active_mask, 4'b1111);
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); #1;
      check("postrst/push", stk_push, 0);
      check("postrst/depth", depth, 0);
    end
    check_state("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard bound on simulation time.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
    $fatal(1, "time limit");
  end

endmodule
